// File: rtl/vga_csr_bank.sv
// vga_csr_bank: control/status register bank for the VGA block, native strobe side of the AXI-Lite slave
//   clk_i, arst_i                          clock, asynchronous active-high reset
//   write_en_i, addr_write_i, data_i       native write strobe, word index, data
//   read_en_i, addr_read_i, data_o         native read strobe, word index, registered read data
//   addr_err_o                             one-cycle pulse on access to an unmapped index
//   vsync_pulse_i, frame_active_i          frame events from the timing generator
//   enable_o, bg_color_o, irq_o            CTRL.EN, shadowed background colour, level interrupt
module vga_csr_bank #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int COLOR_W = 12
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               write_en_i,
    input  logic [ADDR_W-1:0]  addr_write_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               read_en_i,
    input  logic [ADDR_W-1:0]  addr_read_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               addr_err_o,
    input  logic               vsync_pulse_i,
    input  logic               frame_active_i,
    output logic               enable_o,
    output logic [COLOR_W-1:0] bg_color_o,
    output logic               irq_o
);
    logic               en_q, en_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_vs_q, irq_vs_d;
    logic [DATA_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [COLOR_W-1:0] bg_stage_q, bg_stage_d;
    logic [COLOR_W-1:0] bg_color_q, bg_color_d;
    logic               pending_q, pending_d;
    logic [DATA_W-1:0]  scratch_q, scratch_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               addr_err_q, addr_err_d;
    logic               wr_ctrl, wr_irq, wr_bg, wr_scratch, cnt_clr;
    logic [DATA_W-1:0]  rd_val;

    assign wr_ctrl    = write_en_i && addr_write_i == ADDR_W'(0);
    assign wr_irq     = write_en_i && addr_write_i == ADDR_W'(2);
    assign wr_bg      = write_en_i && addr_write_i == ADDR_W'(4);
    assign wr_scratch = write_en_i && addr_write_i == ADDR_W'(5);
    assign cnt_clr    = wr_ctrl && data_i[2];

    always_comb begin
        rd_val = '0;
        case (addr_read_i)
            ADDR_W'(0): rd_val = DATA_W'({irq_en_q, en_q});
            ADDR_W'(1): rd_val = DATA_W'({pending_q, irq_vs_q, frame_active_i});
            ADDR_W'(2): rd_val = DATA_W'(irq_vs_q);
            ADDR_W'(3): rd_val = frame_cnt_q;
            ADDR_W'(4): rd_val = DATA_W'(bg_stage_q);
            ADDR_W'(5): rd_val = scratch_q;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        en_d        = wr_ctrl ? data_i[0] : en_q;
        irq_en_d    = wr_ctrl ? data_i[1] : irq_en_q;
        // vsync set takes priority over a coincident W1C
        irq_vs_d    = vsync_pulse_i ? 1'b1 : (wr_irq && data_i[0]) ? 1'b0 : irq_vs_q;
        // CNT_CLR beats a coincident count
        frame_cnt_d = cnt_clr ? '0 : (vsync_pulse_i && en_q) ? frame_cnt_q + DATA_W'(1) : frame_cnt_q;
        bg_stage_d  = wr_bg ? data_i[COLOR_W-1:0] : bg_stage_q;
        // the shadow copy uses the staged value from before this edge, so a
        // write landing with the vsync stays pending for the next frame
        bg_color_d  = (vsync_pulse_i && pending_q) ? bg_stage_q : bg_color_q;
        pending_d   = wr_bg ? 1'b1 : vsync_pulse_i ? 1'b0 : pending_q;
        scratch_d   = wr_scratch ? data_i : scratch_q;
        data_d      = read_en_i ? rd_val : data_q;
        addr_err_d  = (read_en_i && addr_read_i > ADDR_W'(5)) || (write_en_i && addr_write_i > ADDR_W'(5));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_vs_q    <= 1'b0;
            frame_cnt_q <= '0;
            bg_stage_q  <= '0;
            bg_color_q  <= '0;
            pending_q   <= 1'b0;
            scratch_q   <= '0;
            data_q      <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            irq_vs_q    <= irq_vs_d;
            frame_cnt_q <= frame_cnt_d;
            bg_stage_q  <= bg_stage_d;
            bg_color_q  <= bg_color_d;
            pending_q   <= pending_d;
            scratch_q   <= scratch_d;
            data_q      <= data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign data_o     = data_q;
    assign addr_err_o = addr_err_q;
    assign enable_o   = en_q;
    assign bg_color_o = bg_color_q;
    assign irq_o      = irq_en_q & irq_vs_q;
endmodule

// File: tb/tb_vga_csr_bank.sv
// tb_vga_csr_bank: directed self-checking bench for vga_csr_bank
module tb_vga_csr_bank;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        write_en = 1'b0;
    logic [3:0]  addr_w = '0;
    logic [31:0] data_in = '0;
    logic        read_en = 1'b0;
    logic [3:0]  addr_r = '0;
    logic [31:0] data_out;
    logic        addr_err;
    logic        vsync = 1'b0;
    logic        frame_active = 1'b0;
    logic        enable;
    logic [11:0] bg_color;
    logic        irq;
    int errors = 0;
    int checks = 0;

    vga_csr_bank dut (
        .clk_i(clk), .arst_i(arst),
        .write_en_i(write_en), .addr_write_i(addr_w), .data_i(data_in),
        .read_en_i(read_en), .addr_read_i(addr_r), .data_o(data_out),
        .addr_err_o(addr_err), .vsync_pulse_i(vsync), .frame_active_i(frame_active),
        .enable_o(enable), .bg_color_o(bg_color), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        write_en = 1'b1; addr_w = a; data_in = d;
        tick;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        read_en = 1'b1; addr_r = a;
        tick;
        read_en = 1'b0;
    endtask

    task automatic vs;
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({data_out, addr_err, enable, bg_color, irq} !== 47'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {data_out, addr_err, enable, bg_color, irq});
        end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            checks++;
            if (data_out !== 32'h0) begin
                errors++; $display("FAIL reset_read[%0d]: got %h required 0", i, data_out);
            end
            checks++;
            if (addr_err !== (i > 5)) begin
                errors++; $display("FAIL reset_addr_err[%0d]: got %b required %b", i, addr_err, i > 5);
            end
        end
        tick;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL addr_err_clear: got %b required 0", addr_err);
        end
        read_en = 1'b1; addr_r = 4'd9; write_en = 1'b1; addr_w = 4'd12; data_in = 32'h5;
        tick;
        read_en = 1'b0; write_en = 1'b0;
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL addr_err_both: got %b required 1", addr_err);
        end
        tick;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL addr_err_both_single: got %b required 0", addr_err);
        end
    endtask

    task automatic test_scratch;
        wr(4'd5, 32'hDEADBEEF);
        rd(4'd5);
        checks++;
        if (data_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL scratch_read: got %h required deadbeef", data_out);
        end
        read_en = 1'b1; addr_r = 4'd5; write_en = 1'b1; addr_w = 4'd5; data_in = 32'h12345678;
        tick;
        read_en = 1'b0; write_en = 1'b0;
        checks++;
        if (data_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL scratch_same_cycle: got %h required deadbeef", data_out);
        end
        rd(4'd5);
        checks++;
        if (data_out !== 32'h12345678) begin
            errors++; $display("FAIL scratch_new: got %h required 12345678", data_out);
        end
        tick;
        checks++;
        if (data_out !== 32'h12345678) begin
            errors++; $display("FAIL data_hold: got %h required 12345678", data_out);
        end
    endtask

    task automatic test_irq_count;
        wr(4'd0, 32'h3);
        checks++;
        if (enable !== 1'b1) begin
            errors++; $display("FAIL ctrl_enable: got %b required 1", enable);
        end
        vs; vs; vs;
        rd(4'd3);
        checks++;
        if (data_out !== 32'd3) begin
            errors++; $display("FAIL frame_cnt3: got %h required 3", data_out);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set: got %b required 1", irq);
        end
        frame_active = 1'b1;
        rd(4'd1);
        checks++;
        if (data_out !== 32'h3) begin
            errors++; $display("FAIL status_vs: got %h required 3", data_out);
        end
        // read CTRL while writing W1C to IRQ: both serviced
        read_en = 1'b1; addr_r = 4'd0; write_en = 1'b1; addr_w = 4'd2; data_in = 32'h1;
        tick;
        read_en = 1'b0; write_en = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_w1c: got %b required 0", irq);
        end
        checks++;
        if (data_out !== 32'h3) begin
            errors++; $display("FAIL ctrl_read_parallel: got %h required 3", data_out);
        end
        vsync = 1'b1;
        wr(4'd2, 32'h1);
        vsync = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set_wins: got %b required 1", irq);
        end
        rd(4'd3);
        checks++;
        if (data_out !== 32'd4) begin
            errors++; $display("FAIL frame_cnt4: got %h required 4", data_out);
        end
        wr(4'd2, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_w1c2: got %b required 0", irq);
        end
    endtask

    task automatic test_bg_color;
        wr(4'd4, 32'hFFFF_FABC);
        checks++;
        if (bg_color !== 12'h000) begin
            errors++; $display("FAIL bg_before_vsync: got %h required 000", bg_color);
        end
        rd(4'd1);
        checks++;
        if (data_out !== 32'h5) begin
            errors++; $display("FAIL status_pending: got %h required 5", data_out);
        end
        rd(4'd4);
        checks++;
        if (data_out !== 32'hABC) begin
            errors++; $display("FAIL bg_readback: got %h required abc", data_out);
        end
        vs;
        checks++;
        if (bg_color !== 12'hABC) begin
            errors++; $display("FAIL bg_applied: got %h required abc", bg_color);
        end
        rd(4'd1);
        checks++;
        if (data_out !== 32'h3) begin
            errors++; $display("FAIL status_applied: got %h required 3", data_out);
        end
        vsync = 1'b1;
        wr(4'd4, 32'h123);
        vsync = 1'b0;
        checks++;
        if (bg_color !== 12'hABC) begin
            errors++; $display("FAIL bg_same_cycle: got %h required abc", bg_color);
        end
        rd(4'd1);
        checks++;
        if (data_out[2] !== 1'b1) begin
            errors++; $display("FAIL pending_kept: got %b required 1", data_out[2]);
        end
        vs;
        checks++;
        if (bg_color !== 12'h123) begin
            errors++; $display("FAIL bg_next_vsync: got %h required 123", bg_color);
        end
    endtask

    task automatic test_wrap_clr;
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt_q;
        rd(4'd3);
        checks++;
        if (data_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cnt_forced: got %h required ffffffff", data_out);
        end
        vs;
        rd(4'd3);
        checks++;
        if (data_out !== 32'h0) begin
            errors++; $display("FAIL cnt_wrap: got %h required 0", data_out);
        end
        vs;
        rd(4'd3);
        checks++;
        if (data_out !== 32'h1) begin
            errors++; $display("FAIL cnt_after_wrap: got %h required 1", data_out);
        end
        vsync = 1'b1;
        wr(4'd0, 32'h5);
        vsync = 1'b0;
        rd(4'd3);
        checks++;
        if (data_out !== 32'h0) begin
            errors++; $display("FAIL cnt_clr_wins: got %h required 0", data_out);
        end
        rd(4'd0);
        checks++;
        if (data_out !== 32'h1) begin
            errors++; $display("FAIL ctrl_after_clr: got %h required 1", data_out);
        end
        wr(4'd0, 32'h0);
        wr(4'd4, 32'h456);
        vs;
        rd(4'd3);
        checks++;
        if (data_out !== 32'h0) begin
            errors++; $display("FAIL cnt_disabled: got %h required 0", data_out);
        end
        checks++;
        if (bg_color !== 12'h456) begin
            errors++; $display("FAIL bg_shadow_en0: got %h required 456", bg_color);
        end
    endtask

    task automatic test_async_reset;
        wr(4'd0, 32'h3);
        vs;
        wr(4'd4, 32'h789);
        rd(4'd5);
        checks++;
        if ({irq, enable} !== 2'b11 || data_out !== 32'h12345678) begin
            errors++; $display("FAIL pre_reset: got irq=%b en=%b data=%h required 1 1 12345678", irq, enable, data_out);
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({data_out, addr_err, enable, bg_color, irq} !== 47'd0) begin
            errors++; $display("FAIL async_reset_outputs: got %h required 0", {data_out, addr_err, enable, bg_color, irq});
        end
        frame_active = 1'b0;
        #4;
        arst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(4'(i));
            checks++;
            if (data_out !== 32'h0) begin
                errors++; $display("FAIL post_reset_read[%0d]: got %h required 0", i, data_out);
            end
        end
        vs;
        checks++;
        if (bg_color !== 12'h000) begin
            errors++; $display("FAIL post_reset_pending: got %h required 000", bg_color);
        end
    endtask

    initial begin
        #12;
        arst = 1'b0;
        test_reset;
        test_scratch;
        test_irq_count;
        test_bg_color;
        test_wrap_clr;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
